// File: rtl/div_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Shares the start/fin handshake of the shift-add multiplier.
// Optional feature macro: DIV_ZERO_DETECT_EN adds a div_cero flag and a
// one-edge shortcut to DONE when the divisor is zero.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// RUN   | one shift/subtract/restore step per clock
// DONE  | result valid (fin=1), waiting for start to drop
module div_restoring #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] cociente,
    output logic [WIDTH-1:0] resto,
    output logic             ocupado,
    output logic             fin
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic             div_cero
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    count;

    logic [2*WIDTH:0] aq_sh;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   t_sub;
    logic [WIDTH:0]   a_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last_step;
    logic             zero_div;

    // One restoring step: shift {A,Q}, trial-subtract M, keep or restore.
    always_comb begin
        aq_sh     = {a_reg, q_reg} << 1;
        a_sh      = aq_sh[2*WIDTH:WIDTH];
        t_sub     = a_sh - {1'b0, m_reg};
        a_nxt     = t_sub[WIDTH] ? a_sh : t_sub;
        q_nxt     = aq_sh[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~t_sub[WIDTH]};
        last_step = (count == CW'(1));
`ifdef DIV_ZERO_DETECT_EN
        zero_div  = (divisor == '0);
`else
        zero_div  = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        ocupado   = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = zero_div ? DONE : RUN;
            RUN: begin
                ocupado = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                fin = 1'b1;
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand load, iteration, and result capture on entry to DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg    <= '0;
            q_reg    <= '0;
            m_reg    <= '0;
            count    <= '0;
            cociente <= '0;
            resto    <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_cero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_reg <= '0;
                    q_reg <= dividendo;
                    m_reg <= divisor;
                    count <= CW'(WIDTH);
`ifdef DIV_ZERO_DETECT_EN
                    div_cero <= zero_div;
                    if (zero_div) begin
                        cociente <= '1;
                        resto    <= dividendo;
                    end
`endif
                end
                RUN: begin
                    a_reg <= a_nxt;
                    q_reg <= q_nxt;
                    count <= count - CW'(1);
                    if (last_step) begin
                        cociente <= q_nxt;
                        resto    <= a_nxt[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_restoring.sv
// Self-checking bench for div_restoring (WIDTH=4): directed cases, handshake
// corner cases, async reset abort, random and exhaustive sweeps against a
// plain-arithmetic reference.
module tb_div_restoring;

    localparam int W    = 4;
    localparam int ONES = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividendo = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] cociente;
    logic [W-1:0] resto;
    logic         ocupado;
    logic         fin;
`ifdef DIV_ZERO_DETECT_EN
    logic         div_cero;
`endif

    int total = 0;
    int bad   = 0;

    div_restoring #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .cociente  (cociente),
        .resto     (resto),
        .ocupado   (ocupado),
        .fin       (fin)
`ifdef DIV_ZERO_DETECT_EN
        ,
        .div_cero  (div_cero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_q(input int n, input int d);
        return (d == 0) ? ONES : n / d;
    endfunction

    function automatic int ref_r(input int n, input int d);
        return (d == 0) ? n : n % d;
    endfunction

    // Load n/d with a one-cycle start, wait for fin, check results and timing.
    // disturb: pulse start and scramble operands during RUN.
    task automatic run_div(input int n, input int d, input string tag,
                           input bit chk_lat, input bit disturb);
        int edges;
        int busy;
        @(negedge clk);
        dividendo = W'(n);
        divisor   = W'(d);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        busy  = 0;
        while (fin !== 1'b1 && edges < 40) begin
            busy += (ocupado === 1'b1) ? 1 : 0;
            if (disturb && edges == 2) begin
                start     = 1'b1;
                dividendo = W'(ONES);
                divisor   = W'(1);
            end
            if (disturb && edges == 3) start = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, " fin"}, 32'(fin), 32'd1);
        if (chk_lat) begin
`ifdef DIV_ZERO_DETECT_EN
            chk({tag, " edges"}, 32'(edges), (d == 0) ? 32'd1 : 32'(W + 1));
            chk({tag, " div_cero"}, 32'(div_cero), (d == 0) ? 32'd1 : 32'd0);
`else
            chk({tag, " edges"}, 32'(edges), 32'(W + 1));
            chk({tag, " busy"}, 32'(busy), 32'(W));
`endif
        end
        chk({tag, " cociente"}, 32'(cociente), 32'(ref_q(n, d)));
        chk({tag, " resto"}, 32'(resto), 32'(ref_r(n, d)));
        if (d != 0) begin
            chk({tag, " q*d+r"}, 32'(int'(cociente) * d + int'(resto)), 32'(n));
            chk({tag, " r<d"}, 32'(int'(resto) < d), 32'd1);
        end
        @(posedge clk); #1;
        chk({tag, " idle"}, 32'(fin), 32'd0);
    endtask

    initial begin
        int edges;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst cociente", 32'(cociente), 32'd0);
        chk("rst resto", 32'(resto), 32'd0);
        chk("rst ocupado", 32'(ocupado), 32'd0);
        chk("rst fin", 32'(fin), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // directed results
        run_div(13, 4, "13/4", 1'b1, 1'b0);
        run_div(15, 1, "15/1", 1'b1, 1'b0);
        run_div(7, 9, "7/9", 1'b1, 1'b0);
        run_div(0, 5, "0/5", 1'b1, 1'b0);

        // start held through DONE: no restart, fin stays high
        @(negedge clk);
        dividendo = 4'd13;
        divisor   = 4'd4;
        start     = 1'b1;
        edges = 0;
        while (fin !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("hold edges", 32'(edges), 32'(W + 1));
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold fin", 32'(fin), 32'd1);
            chk("hold ocupado", 32'(ocupado), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("drop fin", 32'(fin), 32'd0);
        chk("drop cociente held", 32'(cociente), 32'd3);
        chk("drop resto held", 32'(resto), 32'd1);

        // start and operand changes during RUN are ignored
        run_div(12, 5, "12/5 disturbed", 1'b1, 1'b1);

        // async reset mid-RUN of 14/3
        @(negedge clk);
        dividendo = 4'd14;
        divisor   = 4'd3;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        chk("pre-rst ocupado", 32'(ocupado), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort cociente", 32'(cociente), 32'd0);
        chk("abort resto", 32'(resto), 32'd0);
        chk("abort ocupado", 32'(ocupado), 32'd0);
        chk("abort fin", 32'(fin), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (W + 2) begin
            @(posedge clk); #1;
            chk("abort no fin", 32'(fin), 32'd0);
        end
        run_div(14, 3, "14/3 after abort", 1'b1, 1'b0);

        // divide by zero, then a normal load
        run_div(11, 0, "11/0", 1'b1, 1'b0);
        run_div(6, 2, "6/2", 1'b1, 1'b0);

        // random operands, including zero divisors
        repeat (40) begin
            int n;
            int d;
            n = int'($urandom_range(0, ONES));
            d = int'($urandom_range(0, ONES));
            run_div(n, d, "rand", 1'b1, 1'b0);
        end

        // exhaustive nonzero-divisor sweep
        for (int n = 0; n <= ONES; n++)
            for (int d = 1; d <= ONES; d++)
                run_div(n, d, "sweep", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
